mod_mult: RTL

- Iterative interleaved (left-to-right, shift-add) modular multiplier. Computes r = (a * b) mod modulus, one multiplier bit per clock.
- Sits directly upstream of the right-to-left binary exponentiator. The exponentiator issues one square and one conditional multiply per exponent bit through this block, then consumes r on done.
- The exponentiator is the only client: single-outstanding-operation start/done handshake, no pipelining.

---
 rtl/mod_mult.sv | 109 ++++++++++
 1 files changed

// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - iterative interleaved shift-add modular multiplier, r = a*b mod modulus
module mod_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mm_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);
  localparam int DW = WIDTH + 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [DW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DW-1:0]    nx, t0, t1, t2;

  // T = 2P + (bit ? A : 0) stays below 3N, so two conditional subtractions reduce it below N
  always_comb begin
    nx = {2'b00, n_q};
    t0 = (p_q << 1) + (b_q[cnt_q] ? {2'b00, a_q} : {DW{1'b0}});
    t1 = (t0 >= nx) ? (t0 - nx) : t0;
    t2 = (t1 >= nx) ? (t1 - nx) : t1;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mm_start) begin
          a_d     = a;
          b_d     = b;
          n_d     = modulus;
          p_d     = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero modulus still walks every bit so latency is data independent; P is pinned at 0
        p_d = (n_q == '0) ? '0 : t2;
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIN: begin
        r_d     = p_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
